axi4_mem_master: RTL and testbench

Initiator end of the core-to-memory AXI4 link. Accepts one load or store at a time from the pipeline's memory stage and drives the address-read, address-write, write-data and write-response channels toward the AXI4 RAM. Returns read data or write completion to the core as a one-cycle response pulse. Sits between the five-stage core's memory stage and the AXI4_Ram slave.

---
 rtl/axi4_mem_master_if.sv | 58 +++++
 rtl/axi4_mem_master.sv | 187 ++++++++++++++++++
 tb/tb_axi4_mem_master.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_mem_master_if.sv
// Bundles the core request/response and AXI4 channel signals of axi4_mem_master.
// The master modport is the block itself; the slave modport is the core plus AXI RAM side.
interface axi4_mem_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_wen;
  logic [ADDR_W-1:0]     req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic [DATA_W/8-1:0]   req_wstrb;

  logic                  resp_valid;
  logic [DATA_W-1:0]     resp_rdata;
  logic                  resp_err;

  logic [ADDR_W-1:0]     axi_awaddr;
  logic                  axi_awvalid;
  logic                  axi_awready;
  logic [DATA_W-1:0]     axi_wdata;
  logic [DATA_W/8-1:0]   axi_wstrb;
  logic                  axi_wvalid;
  logic                  axi_wready;
  logic                  axi_bvalid;
  logic [ADDR_W-1:0]     axi_araddr;
  logic                  axi_arvalid;
  logic                  axi_arready;
  logic [DATA_W-1:0]     axi_rdata;

  modport master (
    input  req_valid, req_wen, req_addr, req_wdata, req_wstrb,
    output req_ready,
    output resp_valid, resp_rdata, resp_err,
    output axi_awaddr, axi_awvalid,
    input  axi_awready,
    output axi_wdata, axi_wstrb, axi_wvalid,
    input  axi_wready,
    input  axi_bvalid,
    output axi_araddr, axi_arvalid,
    input  axi_arready,
    input  axi_rdata
  );

  modport slave (
    output req_valid, req_wen, req_addr, req_wdata, req_wstrb,
    input  req_ready,
    input  resp_valid, resp_rdata, resp_err,
    input  axi_awaddr, axi_awvalid,
    output axi_awready,
    input  axi_wdata, axi_wstrb, axi_wvalid,
    output axi_wready,
    output axi_bvalid,
    input  axi_araddr, axi_arvalid,
    output axi_arready,
    output axi_rdata
  );
endinterface

// File: rtl/axi4_mem_master.sv
// Single-outstanding AXI4 initiator between the core memory stage and the AXI4 RAM.
// Define AXI_MASTER_TIMEOUT_EN to add a watchdog that aborts stalled transactions with resp_err.
module axi4_mem_master #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 64,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clock,
  input  logic                reset,
  axi4_mem_master_if.master   bus
);

  localparam int STRB_W = DATA_W / 8;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("axi4_mem_master: TIMEOUT_CYCLES must be in 1..65535");
  end

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR,
    WR_RESP,
    RESP
  } state_t;

  state_t              state;
  state_t              state_next;

  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   wstrb_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                aw_done;
  logic                w_done;

  logic                accept;
  logic                awvalid;
  logic                wvalid;
  logic                aw_fire;
  logic                w_fire;
  logic                aw_all;
  logic                w_all;
  logic                timed_out;

  assign accept  = (state == IDLE) && bus.req_valid;
  assign awvalid = (state == WR) && !aw_done;
  assign wvalid  = (state == WR) && !w_done;
  assign aw_fire = awvalid && bus.axi_awready;
  assign w_fire  = wvalid && bus.axi_wready;
  // A channel counts as finished if it completed earlier or is completing right now.
  assign aw_all  = aw_done || aw_fire;
  assign w_all   = w_done || w_fire;

  assign bus.req_ready   = (state == IDLE);
  assign bus.resp_valid  = (state == RESP);
  assign bus.resp_rdata  = rdata_q;
  assign bus.axi_arvalid = (state == RD_ADDR);
  assign bus.axi_araddr  = addr_q;
  assign bus.axi_awvalid = awvalid;
  assign bus.axi_awaddr  = addr_q;
  assign bus.axi_wvalid  = wvalid;
  assign bus.axi_wdata   = wdata_q;
  assign bus.axi_wstrb   = wstrb_q;

`ifdef AXI_MASTER_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);

  logic [15:0] timer;
  logic        counting;
  logic        err_q;

  assign counting      = (state == RD_ADDR) || (state == WR) || (state == WR_RESP);
  assign timed_out     = counting && (timer == TIMEOUT_LIM);
  assign bus.resp_err  = err_q;

  // Watchdog restarts on every state change so each wait phase gets the full budget.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      timer <= '0;
    end else if (state_next != state) begin
      timer <= '0;
    end else if (counting) begin
      timer <= timer + 16'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= 1'b0;
    end else if (timed_out) begin
      err_q <= 1'b1;
    end
  end
`else
  assign timed_out    = 1'b0;
  assign bus.resp_err = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // bvalid is only honoured once both AW and W have handshaken, possibly in that same cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          state_next = bus.req_wen ? WR : RD_ADDR;
        end
      end
      RD_ADDR: begin
        if (bus.axi_arready) begin
          state_next = RD_DATA;
        end else if (timed_out) begin
          state_next = RESP;
        end
      end
      RD_DATA: begin
        state_next = RESP;
      end
      WR: begin
        if (aw_all && w_all) begin
          state_next = bus.axi_bvalid ? RESP : WR_RESP;
        end else if (timed_out) begin
          state_next = RESP;
        end
      end
      WR_RESP: begin
        if (bus.axi_bvalid || timed_out) begin
          state_next = RESP;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else if (accept) begin
      addr_q  <= bus.req_addr;
      wdata_q <= bus.req_wdata;
      wstrb_q <= bus.req_wstrb;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else if (accept) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else if (state == WR) begin
      aw_done <= aw_all;
      w_done  <= w_all;
    end
  end

  // Load data persists across stores; an aborted transaction returns zero data.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rdata_q <= '0;
    end else if (state == RD_DATA) begin
      rdata_q <= bus.axi_rdata;
    end else if (timed_out) begin
      rdata_q <= '0;
    end
  end

endmodule

// File: tb/tb_axi4_mem_master.sv
// Directed bench for axi4_mem_master: loads, stores, early bvalid, async reset, back-to-back.
// The timeout scenario runs only when AXI_MASTER_TIMEOUT_EN is defined.
module tb_axi4_mem_master;

  logic clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  axi4_mem_master_if #(.ADDR_W(32), .DATA_W(64)) bus ();

  axi4_mem_master #(
    .ADDR_W(32),
    .DATA_W(64),
    .TIMEOUT_CYCLES(255)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  always #5 clock = ~clock;

  task automatic check_output(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req_valid   = 1'b0;
    bus.req_wen     = 1'b0;
    bus.req_addr    = '0;
    bus.req_wdata   = '0;
    bus.req_wstrb   = '0;
    bus.axi_awready = 1'b0;
    bus.axi_wready  = 1'b0;
    bus.axi_bvalid  = 1'b0;
    bus.axi_arready = 1'b0;
    bus.axi_rdata   = '0;
  endtask

  task automatic apply_stimulus(input logic wen, input logic [31:0] addr,
                                input logic [63:0] wdata, input logic [7:0] wstrb);
    bus.req_valid = 1'b1;
    bus.req_wen   = wen;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_wstrb = wstrb;
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    tick();
    tick();
    check_output("rst_arvalid", bus.axi_arvalid, 0);
    check_output("rst_awvalid", bus.axi_awvalid, 0);
    check_output("rst_wvalid", bus.axi_wvalid, 0);
    check_output("rst_resp_valid", bus.resp_valid, 0);
    check_output("rst_resp_err", bus.resp_err, 0);
    check_output("rst_resp_rdata", bus.resp_rdata, 0);
    reset = 1'b0;
    tick();
    check_output("rst_req_ready", bus.req_ready, 1);

    // Load, zero wait states
    bus.axi_arready = 1'b1;
    apply_stimulus(1'b0, 32'h8000_0008, 64'h0, 8'h00);
    check_output("ld_req_ready", bus.req_ready, 1);
    tick();
    bus.req_valid = 1'b0;
    bus.axi_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
    check_output("ld_arvalid", bus.axi_arvalid, 1);
    check_output("ld_araddr", bus.axi_araddr, 64'h8000_0008);
    check_output("ld_req_ready_busy", bus.req_ready, 0);
    tick();
    bus.axi_rdata = 64'h1122_3344_5566_7788;
    check_output("ld_arvalid_drop", bus.axi_arvalid, 0);
    check_output("ld_no_early_resp", bus.resp_valid, 0);
    tick();
    bus.axi_rdata = 64'hBAD1_BAD1_BAD1_BAD1;
    check_output("ld_resp_valid", bus.resp_valid, 1);
    check_output("ld_resp_rdata", bus.resp_rdata, 64'h1122_3344_5566_7788);
    check_output("ld_resp_err", bus.resp_err, 0);
    tick();
    idle_inputs();
    check_output("ld_resp_pulse", bus.resp_valid, 0);
    check_output("ld_rdata_hold", bus.resp_rdata, 64'h1122_3344_5566_7788);
    check_output("ld_ready_again", bus.req_ready, 1);

    // Store: AW accepted first, W two cycles later, bvalid the cycle after
    bus.axi_awready = 1'b1;
    apply_stimulus(1'b1, 32'h8000_0010, 64'hDEAD_BEEF, 8'h0F);
    tick();
    bus.req_valid = 1'b0;
    check_output("st_awvalid", bus.axi_awvalid, 1);
    check_output("st_wvalid", bus.axi_wvalid, 1);
    check_output("st_awaddr", bus.axi_awaddr, 64'h8000_0010);
    check_output("st_wdata", bus.axi_wdata, 64'hDEAD_BEEF);
    check_output("st_wstrb", bus.axi_wstrb, 64'h0F);
    tick();
    bus.axi_awready = 1'b0;
    check_output("st_aw_dropped", bus.axi_awvalid, 0);
    check_output("st_w_held", bus.axi_wvalid, 1);
    tick();
    bus.axi_wready = 1'b1;
    check_output("st_w_held2", bus.axi_wvalid, 1);
    check_output("st_wdata_stable", bus.axi_wdata, 64'hDEAD_BEEF);
    tick();
    bus.axi_wready = 1'b0;
    bus.axi_bvalid = 1'b1;
    check_output("st_w_dropped", bus.axi_wvalid, 0);
    check_output("st_wait_b", bus.resp_valid, 0);
    tick();
    bus.axi_bvalid = 1'b0;
    check_output("st_resp_valid", bus.resp_valid, 1);
    check_output("st_rdata_kept", bus.resp_rdata, 64'h1122_3344_5566_7788);
    tick();
    check_output("st_single_pulse", bus.resp_valid, 0);

    // Store with bvalid while only AW has completed
    bus.axi_awready = 1'b1;
    apply_stimulus(1'b1, 32'h8000_0020, 64'h0123_4567_89AB_CDEF, 8'hFF);
    tick();
    bus.req_valid = 1'b0;
    tick();
    bus.axi_awready = 1'b0;
    bus.axi_bvalid  = 1'b1;
    check_output("eb_w_pending", bus.axi_wvalid, 1);
    tick();
    bus.axi_bvalid = 1'b0;
    bus.axi_wready = 1'b1;
    check_output("eb_bvalid_ignored", bus.resp_valid, 0);
    check_output("eb_w_still_pending", bus.axi_wvalid, 1);
    tick();
    bus.axi_wready = 1'b0;
    check_output("eb_w_done", bus.axi_wvalid, 0);
    check_output("eb_wait_b", bus.resp_valid, 0);
    tick();
    bus.axi_bvalid = 1'b1;
    check_output("eb_wait_b2", bus.resp_valid, 0);
    tick();
    bus.axi_bvalid = 1'b0;
    check_output("eb_resp_valid", bus.resp_valid, 1);
    tick();

    // Asynchronous reset while arvalid is high
    apply_stimulus(1'b0, 32'h8000_0050, 64'h0, 8'h00);
    tick();
    bus.req_valid = 1'b0;
    check_output("ar_arvalid_before", bus.axi_arvalid, 1);
    #2;
    reset = 1'b1;
    #1;
    check_output("ar_arvalid_async", bus.axi_arvalid, 0);
    check_output("ar_resp_valid", bus.resp_valid, 0);
    check_output("ar_rdata_cleared", bus.resp_rdata, 0);
    bus.axi_arready = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check_output("ar_req_ready", bus.req_ready, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_output("ar_no_resp", bus.resp_valid, 0);
      check_output("ar_no_arvalid", bus.axi_arvalid, 0);
    end

    // Back-to-back store then load, zero-wait slave, bvalid with the handshakes
    bus.axi_awready = 1'b1;
    bus.axi_wready  = 1'b1;
    bus.axi_arready = 1'b1;
    apply_stimulus(1'b1, 32'h8000_0030, 64'hCAFE_F00D, 8'h0F);
    tick();
    bus.req_valid  = 1'b0;
    bus.axi_bvalid = 1'b1;
    check_output("bb_awvalid", bus.axi_awvalid, 1);
    check_output("bb_wvalid", bus.axi_wvalid, 1);
    tick();
    bus.axi_bvalid = 1'b0;
    check_output("bb_st_resp", bus.resp_valid, 1);
    check_output("bb_st_rdata", bus.resp_rdata, 0);
    tick();
    check_output("bb_ready_next", bus.req_ready, 1);
    apply_stimulus(1'b0, 32'h8000_0040, 64'h0, 8'h00);
    tick();
    bus.req_valid = 1'b0;
    check_output("bb_arvalid", bus.axi_arvalid, 1);
    check_output("bb_araddr", bus.axi_araddr, 64'h8000_0040);
    tick();
    bus.axi_rdata = 64'hA5A5_5A5A_0F0F_F0F0;
    check_output("bb_no_early_resp", bus.resp_valid, 0);
    tick();
    bus.axi_rdata = '0;
    check_output("bb_ld_resp", bus.resp_valid, 1);
    check_output("bb_ld_rdata", bus.resp_rdata, 64'hA5A5_5A5A_0F0F_F0F0);
    tick();
    idle_inputs();

`ifdef AXI_MASTER_TIMEOUT_EN
    // Watchdog: arready never arrives
    apply_stimulus(1'b0, 32'h8000_0060, 64'h0, 8'h00);
    tick();
    bus.req_valid = 1'b0;
    for (int i = 0; i < 255; i++) begin
      tick();
    end
    check_output("to_arvalid_last", bus.axi_arvalid, 1);
    tick();
    check_output("to_arvalid_drop", bus.axi_arvalid, 0);
    check_output("to_resp_valid", bus.resp_valid, 1);
    check_output("to_resp_err", bus.resp_err, 1);
    check_output("to_resp_rdata", bus.resp_rdata, 0);
    tick();
    check_output("to_idle", bus.req_ready, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
